// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line in, received byte / status out for uart_rx
//
// Signals:
//   line       serial input, idle high, 8N1, LSB first (asynchronous to clk)
//   ack        consumer acknowledge of the held byte
//   data[7:0]  last correctly received byte
//   valid      level: data holds an unacknowledged byte
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: good byte dropped because valid was still high
//
// Modports: master = line driver / byte consumer, slave = receiver.
interface uart_rx_if;
  logic       line;
  logic       ack;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;

  modport master (output line, ack, input data, valid, frame_err, overrun);
  modport slave  (input line, ack, output data, valid, frame_err, overrun);
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with held output byte, frame error and overrun pulses
//
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous active-high reset
//   bus   uart_rx_if.slave: line/ack in; data/valid/frame_err/overrun out
// Parameter CLKS_PER_BIT: clk cycles per serial bit, even, 4..255.
module uart_rx #(
  parameter int CLKS_PER_BIT = 120
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);

  localparam logic [7:0] H = 8'(CLKS_PER_BIT / 2);
  localparam logic [7:0] C = 8'(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t     state, state_n;
  logic       sync1, sync2;
  logic [7:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic [7:0] data_q, data_n;
  logic       valid_q, valid_n;
  logic       ferr_q, ferr_n;
  logic       ovr_q, ovr_n;
  logic       s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.line;
      sync2 <= sync1;
    end
  end

  assign s = sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      idx     <= 3'd0;
      shift   <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      shift   <= shift_n;
      data_q  <= data_n;
      valid_q <= valid_n;
      ferr_q  <= ferr_n;
      ovr_q   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shift_n = shift;
    data_n  = data_q;
    valid_n = valid_q;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;

    // Acknowledge clears the held byte; a delivery in the same cycle
    // below overrides this and keeps valid high with the new byte.
    if (bus.ack && valid_q) valid_n = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = 8'd0;
        if (!s) state_n = START;
      end
      START: begin
        // Re-check the line at mid start bit to reject short glitches.
        if (cnt == H - 8'd1) begin
          cnt_n   = 8'd0;
          idx_n   = 3'd0;
          state_n = s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DATA: begin
        if (cnt == C - 8'd1) begin
          cnt_n        = 8'd0;
          shift_n[idx] = s;
          if (idx == 3'd7) state_n = STOP;
          else             idx_n   = idx + 3'd1;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      STOP: begin
        if (cnt == C - 8'd1) begin
          cnt_n = 8'd0;
          if (s) begin
            state_n = IDLE;
            if (!valid_q || bus.ack) begin
              data_n  = shift;
              valid_n = 1'b1;
            end else begin
              ovr_n = 1'b1;
            end
          end else begin
            ferr_n  = 1'b1;
            state_n = WAIT_HIGH;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      WAIT_HIGH: begin
        // A held-low (break) line must return high before a new start.
        cnt_n = 8'd0;
        if (s) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = 8'd0;
      end
    endcase
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule
